alu_seq_param: RTL and testbench

//  Parametrised multi-cycle sequential ALU, WIDTH-bit successor of the 8-bit datapath ALU.
//  Ops: signed add, signed sub, radix-2 Booth signed multiply, unsigned restoring divide (2W/W).

---
 rtl/alu_seq_param.sv | 157 +++++++++++++++
 tb/tb_alu_seq_param.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_param.sv
// Multi-cycle sequential ALU: signed add/sub, Booth signed multiply, restoring 2W/W divide.
// Operands arrive serially on inbus (X then M); result is registered and held on outbus.
module alu_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         sel,
    input  logic [2*WIDTH-1:0] inbus,
    output logic [2*WIDTH-1:0] outbus,
    output logic               busy,
    output logic               finish,
    output logic               of_flag,
    output logic               dbz_flag
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOADM  = 3'd1;
    localparam logic [2:0] S_ADDSUB = 3'd2;
    localparam logic [2:0] S_MUL    = 3'd3;
    localparam logic [2:0] S_DIV    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]         r_state;
    logic [1:0]         r_sel;
    logic [2*WIDTH-1:0] r_x;
    logic [WIDTH-1:0]   r_a, r_q, r_m;
    logic               r_qm1;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH:0]     w_as, w_a_ext, w_m_ext, w_booth, w_r, w_rsub;
    logic               w_of, w_bsign, w_ge, w_first;

    // Add/sub on W+1 bits; overflow judged on the effective (post-inversion) sign of M.
    assign w_as    = r_sel[0] ? ({r_x[WIDTH-1], r_x[WIDTH-1:0]} - {r_m[WIDTH-1], r_m})
                              : ({r_x[WIDTH-1], r_x[WIDTH-1:0]} + {r_m[WIDTH-1], r_m});
    assign w_bsign = r_sel[0] ? ~r_m[WIDTH-1] : r_m[WIDTH-1];
    assign w_of    = (r_x[WIDTH-1] == w_bsign) && (w_as[WIDTH-1] != r_x[WIDTH-1]);

    assign w_a_ext = {r_a[WIDTH-1], r_a};
    assign w_m_ext = {r_m[WIDTH-1], r_m};

    always_comb begin
        w_booth = w_a_ext;
        case ({r_q[0], r_qm1})
            2'b01:   w_booth = w_a_ext + w_m_ext;
            2'b10:   w_booth = w_a_ext - w_m_ext;
            default: w_booth = w_a_ext;
        endcase
    end

    assign w_r     = {r_a, r_q[WIDTH-1]};
    assign w_ge    = (w_r >= {1'b0, r_m});
    assign w_rsub  = w_r - {1'b0, r_m};
    assign w_first = (r_cnt == CW'(WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sel    <= '0;
            r_x      <= '0;
            r_a      <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_qm1    <= 1'b0;
            r_cnt    <= '0;
            outbus   <= '0;
            busy     <= 1'b0;
            finish   <= 1'b0;
            of_flag  <= 1'b0;
            dbz_flag <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    finish <= 1'b0;
                    if (start) begin
                        r_sel    <= sel;
                        r_x      <= inbus;
                        of_flag  <= 1'b0;
                        dbz_flag <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= S_LOADM;
                    end
                end
                S_LOADM: begin
                    r_m   <= inbus[WIDTH-1:0];
                    r_cnt <= CW'(WIDTH);
                    case (r_sel)
                        2'b10: begin
                            r_a     <= '0;
                            r_q     <= r_x[WIDTH-1:0];
                            r_qm1   <= 1'b0;
                            r_state <= S_MUL;
                        end
                        2'b11: begin
                            {r_a, r_q} <= r_x;
                            r_state    <= S_DIV;
                        end
                        default: r_state <= S_ADDSUB;
                    endcase
                end
                S_ADDSUB: begin
                    outbus  <= {{WIDTH{1'b0}}, w_as[WIDTH-1:0]};
                    of_flag <= w_of;
                    finish  <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_DONE;
                end
                S_MUL: begin
                    if (r_cnt != '0) begin
                        // Arithmetic shift of {A,Q,q_m1}; A's new sign comes from the W+1-bit sum.
                        r_a   <= w_booth[WIDTH:1];
                        r_q   <= {w_booth[0], r_q[WIDTH-1:1]};
                        r_qm1 <= r_q[0];
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        outbus  <= {r_a, r_q};
                        finish  <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (w_first && (r_m == '0)) begin
                        dbz_flag <= 1'b1;
                        outbus   <= '1;
                        finish   <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= S_DONE;
                    end else if (w_first && (r_a >= r_m)) begin
                        of_flag <= 1'b1;
                        outbus  <= r_x;
                        finish  <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_cnt != '0) begin
                        r_a   <= w_ge ? w_rsub[WIDTH-1:0] : w_r[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], w_ge};
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        outbus  <= {r_a, r_q};
                        finish  <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    finish  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_param.sv
// Scoreboard bench for alu_seq_param at WIDTH=8 (directed + random) and WIDTH=16 (random).
module tb_alu_seq_param;
    typedef struct {
        longint res;
        bit     of;
        bit     dbz;
        int     lat;
        int     t0;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst16;
    logic        start8, start16;
    logic [1:0]  sel8, sel16;
    logic [15:0] in8, out8;
    logic [31:0] in16, out16;
    logic        busy8, fin8, of8, dbz8;
    logic        busy16, fin16, of16, dbz16;

    alu_seq_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sel(sel8), .inbus(in8),
        .outbus(out8), .busy(busy8), .finish(fin8), .of_flag(of8), .dbz_flag(dbz8)
    );
    alu_seq_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst16), .start(start16), .sel(sel16), .inbus(in16),
        .outbus(out16), .busy(busy16), .finish(fin16), .of_flag(of16), .dbz_flag(dbz16)
    );

    exp_t q8[$], q16[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0;
    bit   done16 = 1'b0, pf8 = 1'b0, pf16 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string n, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    // Reference results straight from the arithmetic definitions of each op.
    function automatic exp_t model(input int w, input int s, input longint x, input longint m);
        exp_t   e;
        longint one = 1;
        longint msk = (one << w) - 1;
        longint msk2 = (one << (2 * w)) - 1;
        longint sb = one << (w - 1);
        longint xl = x & msk;
        longint ml = m & msk;
        longint xx = x & msk2;
        longint r, sx, sm;
        e.of = 0; e.dbz = 0; e.lat = 3; e.t0 = 0; e.res = 0;
        case (s)
            0: begin
                r = (xl + ml) & msk;
                e.of = ((xl & sb) == (ml & sb)) && ((r & sb) != (xl & sb));
                e.res = r;
            end
            1: begin
                r = (xl - ml) & msk;
                e.of = ((xl & sb) != (ml & sb)) && ((r & sb) != (xl & sb));
                e.res = r;
            end
            2: begin
                sx = ((xl & sb) != 0) ? xl - (one << w) : xl;
                sm = ((ml & sb) != 0) ? ml - (one << w) : ml;
                e.res = (sx * sm) & msk2;
                e.lat = w + 3;
            end
            default: begin
                if (ml == 0) begin
                    e.dbz = 1; e.res = msk2;
                end else if ((xx >> w) >= ml) begin
                    e.of = 1; e.res = xx;
                end else begin
                    e.res = ((xx % ml) << w) | (xx / ml);
                    e.lat = w + 3;
                end
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (fin8) begin
                if (q8.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL fin8_unexpected: finish with empty scoreboard");
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    check("out8", longint'(out8), e.res);
                    check("of8", longint'(of8), longint'(e.of));
                    check("dbz8", longint'(dbz8), longint'(e.dbz));
                    check("lat8", longint'(cyc - e.t0), longint'(e.lat));
                    check("busy8_at_fin", longint'(busy8), 0);
                    check("fin8_pulse", longint'(pf8), 0);
                end
            end
            pf8 = fin8;
        end else pf8 = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst16) begin
            if (fin16) begin
                if (q16.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL fin16_unexpected: finish with empty scoreboard");
                end else begin
                    exp_t e;
                    e = q16.pop_front();
                    check("out16", longint'(out16), e.res);
                    check("of16", longint'(of16), longint'(e.of));
                    check("dbz16", longint'(dbz16), longint'(e.dbz));
                    check("lat16", longint'(cyc - e.t0), longint'(e.lat));
                    check("fin16_pulse", longint'(pf16), 0);
                end
            end
            pf16 = fin16;
        end else pf16 = 1'b0;
    end

    task automatic op8(input int s, input longint x, input longint m, input bit hold);
        exp_t e;
        int   k;
        e = model(8, s, x, m);
        @(negedge clk);
        start8 = 1'b1; sel8 = 2'(s); in8 = 16'(x);
        e.t0 = cyc;
        q8.push_back(e);
        @(negedge clk);
        start8 = hold; sel8 = ~2'(s); in8 = 16'(m);
        k = 0;
        do begin @(negedge clk); k++; end while (!fin8 && k < 200);
        if (!fin8) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout8: no finish after %0d cycles", k);
        end
        @(negedge clk);
        start8 = 1'b0;
        check("hold8", longint'(out8), e.res);
        check("idle_busy8", longint'(busy8), 0);
    endtask

    task automatic op16(input int s, input longint x, input longint m, input bit hold);
        exp_t e;
        int   k;
        e = model(16, s, x, m);
        @(negedge clk);
        start16 = 1'b1; sel16 = 2'(s); in16 = 32'(x);
        e.t0 = cyc;
        q16.push_back(e);
        @(negedge clk);
        start16 = hold; sel16 = ~2'(s); in16 = 32'(m);
        k = 0;
        do begin @(negedge clk); k++; end while (!fin16 && k < 200);
        if (!fin16) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout16: no finish after %0d cycles", k);
        end
        @(negedge clk);
        start16 = 1'b0;
        check("hold16", longint'(out16), e.res);
    endtask

    function automatic longint rand_x(input int w, input int s, input longint m);
        longint one = 1;
        longint x = {$urandom, $urandom};
        x = x & ((one << (2 * w)) - 1);
        if (s == 3 && m != 0 && $urandom_range(0, 3) != 0)
            x = (longint'($urandom_range(0, int'(m - 1))) << w) | (x & ((one << w) - 1));
        return x;
    endfunction

    initial begin
        rst16 = 1'b1; start16 = 1'b0; sel16 = '0; in16 = '0;
        repeat (2) @(negedge clk);
        rst16 = 1'b0;
        for (int i = 0; i < 120; i++) begin
            int     s;
            longint m;
            s = $urandom_range(0, 3);
            m = ($urandom_range(0, 15) == 0) ? 0 : longint'($urandom_range(0, 65535));
            op16(s, rand_x(16, s, m), m, $urandom_range(0, 1) == 1);
        end
        done16 = 1'b1;
    end

    initial begin
        rst = 1'b1; start8 = 1'b0; sel8 = '0; in8 = '0;
        #1;
        check("rst_out", longint'(out8), 0);
        check("rst_busy", longint'(busy8), 0);
        check("rst_fin", longint'(fin8), 0);
        check("rst_of", longint'(of8), 0);
        check("rst_dbz", longint'(dbz8), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        op8(0, 20, 75, 0);
        op8(0, 127, 126, 0);
        op8(1, 'h80, 'h01, 1);
        op8(1, 178, 34, 0);
        op8(2, 'hE7, 'hD6, 1);
        op8(2, 'hE9, 75, 0);
        op8(2, 'h80, 'h80, 0);
        op8(3, 2739, 25, 1);
        op8(3, 1234, 0, 0);
        op8(3, 'h1A00, 'h10, 0);
        op8(0, 'h7F, 'h01, 0);

        // Abort a multiply mid-flight with an asynchronous reset.
        @(negedge clk);
        start8 = 1'b1; sel8 = 2'b10; in8 = 16'h00E7;
        @(negedge clk);
        start8 = 1'b0; in8 = 16'h00D6;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_out", longint'(out8), 0);
        check("abort_busy", longint'(busy8), 0);
        check("abort_fin", longint'(fin8), 0);
        check("abort_of", longint'(of8), 0);
        @(negedge clk);
        rst = 1'b0;
        op8(0, 20, 75, 0);

        for (int i = 0; i < 150; i++) begin
            int     s;
            longint m;
            s = $urandom_range(0, 3);
            m = ($urandom_range(0, 15) == 0) ? 0 : longint'($urandom_range(0, 255));
            op8(s, rand_x(8, s, m), m, $urandom_range(0, 1) == 1);
        end

        while (!done16) @(negedge clk);
        repeat (3) @(negedge clk);
        check("q8_drained", longint'(q8.size()), 0);
        check("q16_drained", longint'(q16.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
